// File: rtl/tetris_pkg.sv
// Shared game-state encodings and board/shape layout constants for the Tetris
// main state machine, the board datapath and the display driver.
package tetris_pkg;

  typedef enum logic [2:0] {
    ST_GEN      = 3'b000,
    ST_MOVE     = 3'b001,
    ST_LAND     = 3'b010,
    ST_CLEAR    = 3'b011,
    ST_NEWBOARD = 3'b100,
    ST_GAMEOVER = 3'b101
  } game_state_e;

  localparam int DEF_ROWS = 16;
  localparam int DEF_COLS = 8;

  // Shape mask: bit r*SHAPE_DIM+c is piece row r, column c (top/left justified).
  localparam int SHAPE_DIM  = 4;
  localparam int SHAPE_BITS = SHAPE_DIM * SHAPE_DIM;

endpackage

// File: rtl/piece_collide.sv
// Combinational collision test of a 4x4 shape placed at (x, y) against the board.
// x and y are one bit wider than the board coordinates so x+1 / y+1 never wrap.
module piece_collide
  import tetris_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int XW   = $clog2(COLS),
  parameter int YW   = $clog2(ROWS)
) (
  input  logic [ROWS*COLS-1:0]  board,
  input  logic [SHAPE_BITS-1:0] mask,
  input  logic [XW:0]           x,
  input  logic [YW:0]           y,
  output logic                  hit
);

  logic [SHAPE_BITS-1:0] cell_hit;

  genvar gi;
  generate
    for (gi = 0; gi < SHAPE_BITS; gi++) begin : g_cell
      localparam int R = gi / SHAPE_DIM;
      localparam int C = gi % SHAPE_DIM;
      logic [XW+1:0] cx;
      logic [YW+1:0] cy;
      logic [15:0]   idx;
      logic          occ;

      assign cx  = {1'b0, x} + (XW+2)'(C);
      assign cy  = {1'b0, y} + (YW+2)'(R);
      assign idx = 16'(cy) * 16'(COLS) + 16'(cx);
      // Out-of-range cells are flagged by the bounds terms, so occ may alias freely there.
      assign occ = |(board & ((ROWS*COLS)'(1) << idx));
      assign cell_hit[gi] = mask[gi] &
                            ((cx >= (XW+2)'(COLS)) | (cy >= (YW+2)'(ROWS)) | occ);
    end
  endgenerate

  assign hit = |cell_hit;

endmodule

// File: rtl/piece_drop_ctrl.sv
// Board datapath for the Tetris main state machine: owns the occupancy board,
// spawns/moves the active piece, applies gravity and merges landed pieces.
module piece_drop_ctrl
  import tetris_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int DROP_TICKS = 50,
  parameter int SPAWN_X    = 2
) (
  input  logic                    clka,
  input  logic                    restart,
  input  logic [2:0]              state,
  input  logic [SHAPE_BITS-1:0]   piece_mask,
  input  logic                    btn_left,
  input  logic                    btn_right,
  output logic                    placed,
  output logic                    game_over,
  output logic [ROWS*COLS-1:0]    board,
  output logic [$clog2(COLS)-1:0] piece_x,
  output logic [$clog2(ROWS)-1:0] piece_y,
  output logic [SHAPE_BITS-1:0]   piece_cur
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int CW = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
  localparam int NB = ROWS * COLS;

  logic [NB-1:0]         board_q, board_d;
  logic [SHAPE_BITS-1:0] cur_q, cur_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  placed_q, placed_d;

  logic hit_spawn, hit_down, hit_left, hit_right;
  logic wrap;
  logic [NB-1:0] piece_board;
  logic [NB-1:0] cell_vec [SHAPE_BITS];

  piece_collide #(.ROWS(ROWS), .COLS(COLS), .XW(XW), .YW(YW)) u_spawn (
    .board(board_q), .mask(piece_mask),
    .x((XW+1)'(SPAWN_X)), .y('0), .hit(hit_spawn)
  );

  piece_collide #(.ROWS(ROWS), .COLS(COLS), .XW(XW), .YW(YW)) u_down (
    .board(board_q), .mask(cur_q),
    .x({1'b0, x_q}), .y({1'b0, y_q} + 1'b1), .hit(hit_down)
  );

  // At x=0 this wraps to a large value and reports a hit; the move is also gated on x>0.
  piece_collide #(.ROWS(ROWS), .COLS(COLS), .XW(XW), .YW(YW)) u_left (
    .board(board_q), .mask(cur_q),
    .x({1'b0, x_q} - 1'b1), .y({1'b0, y_q}), .hit(hit_left)
  );

  piece_collide #(.ROWS(ROWS), .COLS(COLS), .XW(XW), .YW(YW)) u_right (
    .board(board_q), .mask(cur_q),
    .x({1'b0, x_q} + 1'b1), .y({1'b0, y_q}), .hit(hit_right)
  );

  // Active piece expanded onto the board; off-board cells are dropped.
  genvar gi;
  generate
    for (gi = 0; gi < SHAPE_BITS; gi++) begin : g_merge
      localparam int R = gi / SHAPE_DIM;
      localparam int C = gi % SHAPE_DIM;
      logic [XW+1:0] cx;
      logic [YW+1:0] cy;
      logic [15:0]   idx;
      logic          in_range;

      assign cx       = {2'b00, x_q} + (XW+2)'(C);
      assign cy       = {2'b00, y_q} + (YW+2)'(R);
      assign idx      = 16'(cy) * 16'(COLS) + 16'(cx);
      assign in_range = (cx < (XW+2)'(COLS)) && (cy < (YW+2)'(ROWS));
      assign cell_vec[gi] = (cur_q[gi] && in_range) ? (NB'(1) << idx) : '0;
    end
  endgenerate

  always_comb begin
    piece_board = '0;
    for (int i = 0; i < SHAPE_BITS; i++) begin
      piece_board = piece_board | cell_vec[i];
    end
  end

  assign wrap = (cnt_q == CW'(DROP_TICKS - 1));

  always_comb begin
    board_d  = board_q;
    cur_d    = cur_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    placed_d = 1'b0;
    case (game_state_e'(state))
      ST_NEWBOARD: begin
        board_d = '0;
        cnt_d   = '0;
      end
      ST_GEN: begin
        cur_d = piece_mask;
        x_d   = XW'(SPAWN_X);
        y_d   = '0;
        cnt_d = '0;
      end
      ST_MOVE: begin
        placed_d = placed_q;
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        if (!placed_q) begin
          if (wrap) begin
            if (!hit_down) y_d = y_q + 1'b1;
            else           placed_d = 1'b1;
          end else if (btn_left && !btn_right) begin
            if ((x_q != '0) && !hit_left) x_d = x_q - 1'b1;
          end else if (btn_right && !btn_left) begin
            if (!hit_right) x_d = x_q + 1'b1;
          end
        end
      end
      ST_LAND: begin
        board_d = board_q | piece_board;
      end
      default: ;
    endcase
  end

  always_comb begin
    game_over = 1'b0;
    case (game_state_e'(state))
      ST_GEN:  game_over = hit_spawn;
      ST_LAND: game_over = |(board_q[COLS-1:0] | piece_board[COLS-1:0]);
      default: game_over = 1'b0;
    endcase
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      board_q  <= '0;
      cur_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      placed_q <= 1'b0;
    end else begin
      board_q  <= board_d;
      cur_q    <= cur_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      placed_q <= placed_d;
    end
  end

  assign placed    = placed_q;
  assign board     = board_q;
  assign piece_x   = x_q;
  assign piece_y   = y_q;
  assign piece_cur = cur_q;

endmodule

// File: tb/tb_piece_drop_ctrl.sv
// Scoreboard bench for piece_drop_ctrl: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_piece_drop_ctrl;
  import tetris_pkg::*;

  localparam int ROWS = 16;
  localparam int COLS = 8;

  logic         clka = 1'b0;
  logic         restart;
  logic [2:0]   state;
  logic [15:0]  piece_mask;
  logic         btn_left, btn_right;
  logic         placed, game_over;
  logic [127:0] board;
  logic [2:0]   piece_x;
  logic [3:0]   piece_y;
  logic [15:0]  piece_cur;

  piece_drop_ctrl #(.ROWS(ROWS), .COLS(COLS), .DROP_TICKS(4), .SPAWN_X(2)) dut (
    .clka(clka), .restart(restart), .state(state), .piece_mask(piece_mask),
    .btn_left(btn_left), .btn_right(btn_right), .placed(placed),
    .game_over(game_over), .board(board), .piece_x(piece_x),
    .piece_y(piece_y), .piece_cur(piece_cur)
  );

  always #5 clka = ~clka;

  typedef enum int {F_BOARD, F_PLACED, F_GO, F_X, F_Y, F_CUR} fld_e;
  typedef struct {
    int           cyc;
    string        name;
    fld_e         fld;
    logic [127:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clka) cyc <= cyc + 1;

  function automatic logic [127:0] fetch(fld_e f);
    case (f)
      F_BOARD:  return board;
      F_PLACED: return 128'(placed);
      F_GO:     return 128'(game_over);
      F_X:      return 128'(piece_x);
      F_Y:      return 128'(piece_y);
      default:  return 128'(piece_cur);
    endcase
  endfunction

  // Monitor: compares every expectation tagged with the current cycle.
  always @(negedge clka) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [127:0] act;
      e   = sb.pop_front();
      act = fetch(e.fld);
      tests++;
      if (e.cyc != cyc || act !== e.val) begin
        fails++;
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", e.name, act, e.val, e.cyc);
      end else begin
        $display("[TB] ok %s = %0h", e.name, act);
      end
    end
  end

  task automatic expect_v(string nm, fld_e f, logic [127:0] v);
    sb.push_back('{cyc, nm, f, v});
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clka);
      #1;
    end
  endtask

  typedef struct packed {
    logic       l;
    logic       r;
    logic [2:0] x;
    logic [3:0] y;
  } vec_t;

  // One row per MOVE cycle after spawn at x=2; rows 4,8,... are gravity (wrap) cycles.
  vec_t lat_tbl [24] = '{
    '{1'b1, 1'b0, 3'd1, 4'd0}, '{1'b1, 1'b0, 3'd0, 4'd0}, '{1'b1, 1'b0, 3'd0, 4'd0},
    '{1'b0, 1'b0, 3'd0, 4'd1}, '{1'b1, 1'b1, 3'd0, 4'd1}, '{1'b0, 1'b1, 3'd1, 4'd1},
    '{1'b0, 1'b1, 3'd2, 4'd1}, '{1'b0, 1'b0, 3'd2, 4'd2}, '{1'b0, 1'b1, 3'd3, 4'd2},
    '{1'b0, 1'b1, 3'd4, 4'd2}, '{1'b0, 1'b1, 3'd5, 4'd2}, '{1'b0, 1'b0, 3'd5, 4'd3},
    '{1'b0, 1'b1, 3'd6, 4'd3}, '{1'b0, 1'b1, 3'd6, 4'd3}, '{1'b0, 1'b0, 3'd6, 4'd3},
    '{1'b1, 1'b0, 3'd6, 4'd4}, '{1'b1, 1'b0, 3'd5, 4'd4}, '{1'b1, 1'b0, 3'd4, 4'd4},
    '{1'b1, 1'b0, 3'd3, 4'd4}, '{1'b0, 1'b0, 3'd3, 4'd5}, '{1'b1, 1'b0, 3'd2, 4'd5},
    '{1'b1, 1'b0, 3'd1, 4'd5}, '{1'b1, 1'b0, 3'd0, 4'd5}, '{1'b0, 1'b0, 3'd0, 4'd6}
  };

  logic [127:0] board_exp;
  int           n;
  int           ey;

  initial begin
    restart    = 1'b1;
    state      = 3'b001;
    piece_mask = 16'h0000;
    btn_left   = 1'b0;
    btn_right  = 1'b0;

    // Reset while MOVE is presented
    tick();
    expect_v("rst_board",  F_BOARD,  '0);
    expect_v("rst_placed", F_PLACED, 0);
    expect_v("rst_x",      F_X,      0);
    expect_v("rst_y",      F_Y,      0);
    expect_v("rst_cur",    F_CUR,    0);
    restart = 1'b0;
    state   = 3'b100;
    expect_v("newboard_go", F_GO, 0);
    tick();

    // Spawn O-piece
    state      = 3'b000;
    piece_mask = 16'h0033;
    expect_v("gen_go_empty", F_GO, 0);
    tick();
    state = 3'b001;
    expect_v("gen_cur", F_CUR, 128'h33);
    expect_v("gen_x",   F_X,   2);
    expect_v("gen_y",   F_Y,   0);

    // Lateral limits, both-buttons, and a request dropped on the gravity cycle
    for (int i = 0; i < 24; i++) begin
      btn_left  = lat_tbl[i].l;
      btn_right = lat_tbl[i].r;
      tick();
      btn_left  = 1'b0;
      btn_right = 1'b0;
      expect_v($sformatf("lat_x_c%0d", i + 1), F_X, 128'(lat_tbl[i].x));
      expect_v($sformatf("lat_y_c%0d", i + 1), F_Y, 128'(lat_tbl[i].y));
    end

    // Free fall to the floor, then placed rises on the blocked wrap and holds
    for (int c = 25; c <= 64; c++) begin
      tick();
      ey = (c / 4 > 14) ? 14 : c / 4;
      expect_v($sformatf("fall_y_c%0d", c), F_Y, 128'(ey));
      expect_v($sformatf("fall_placed_c%0d", c), F_PLACED, (c >= 60) ? 1 : 0);
    end
    expect_v("fall_x", F_X, 0);

    // Merge at rows 14-15, columns 0-1
    state = 3'b010;
    expect_v("land_placed_held", F_PLACED, 1);
    expect_v("land_go_o", F_GO, 0);
    tick();
    board_exp = (128'h3 << 112) | (128'h3 << 120);
    expect_v("merge_o_board", F_BOARD, board_exp);
    expect_v("land_placed_clr", F_PLACED, 0);
    tick();
    expect_v("merge_idempotent", F_BOARD, board_exp);

    // Stack four vertical I-pieces in column 2 up to row 0
    for (int k = 0; k < 4; k++) begin
      state      = 3'b000;
      piece_mask = 16'h1111;
      expect_v($sformatf("stack_gen_go_%0d", k), F_GO, 0);
      tick();
      state = 3'b001;
      n = 0;
      while (!placed && n < 100) begin
        tick();
        n++;
      end
      if (n >= 100) begin
        tests++;
        fails++;
        $display("FAIL stack_wait_%0d: placed still %0d after %0d cycles, required 1", k, placed, n);
      end
      expect_v($sformatf("stack_y_%0d", k), F_Y, 128'(12 - 4 * k));
      expect_v($sformatf("stack_x_%0d", k), F_X, 2);
      state = 3'b010;
      expect_v($sformatf("stack_land_go_%0d", k), F_GO, (k == 3) ? 1 : 0);
      tick();
      for (int r = 12 - 4 * k; r < 16 - 4 * k; r++) begin
        board_exp = board_exp | (128'h1 << (r * 8 + 2));
      end
      expect_v($sformatf("stack_board_%0d", k), F_BOARD, board_exp);
    end

    // Spawn blocked at SPAWN_X
    state      = 3'b000;
    piece_mask = 16'h0033;
    expect_v("spawn_blocked_go", F_GO, 1);
    tick();

    // GAMEOVER holds the board and keeps placed low
    state = 3'b101;
    expect_v("gameover_go", F_GO, 0);
    tick(3);
    expect_v("gameover_board", F_BOARD, board_exp);
    expect_v("gameover_placed", F_PLACED, 0);

    // Restart during LAND wins over the merge
    state   = 3'b010;
    restart = 1'b1;
    tick();
    expect_v("rst_land_board", F_BOARD, '0);
    expect_v("rst_land_cur",   F_CUR,   0);
    expect_v("rst_land_y",     F_Y,     0);
    restart = 1'b0;
    tick();
    expect_v("rst_land_nomerge", F_BOARD, '0);
    state = 3'b100;
    tick(2);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: never compared, required %0h", e.name, e.val);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
